// File: rtl/dm_responder.sv
// Variable-latency data-memory responder for the M-stage load/store port.
// One request at a time: capture, count LATENCY wait cycles, then pulse ready for one cycle.
module dm_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, nextState;
  logic [3:0]          cnt, nextCnt;
  logic                capture, enterResp;

  logic                capWe, capMis;
  logic [ADDR_W-1:0]   capIdx;
  logic [3:0]          capBe;
  logic [31:0]         capWdata;

  logic                effWe, effMis;
  logic [ADDR_W-1:0]   effIdx;
  logic [3:0]          effBe;
  logic [31:0]         effWdata;

  logic [31:0]         mem [0:(1 << ADDR_W) - 1];

  // Upper address bits alias by design.
  logic                unusedAddr;
  assign unusedAddr = ^addr[31:ADDR_W+2];

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    capture   = 1'b0;
    enterResp = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          nextCnt = 4'(LATENCY);
          if (LATENCY == 0) begin
            nextState = RESP;
            enterResp = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        nextCnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          nextState = RESP;
          enterResp = 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // With zero latency the request is captured and answered on the same edge,
  // so the response path must see the live inputs instead of the capture registers.
  always_comb begin
    effWe    = capture ? we : capWe;
    effMis   = capture ? (addr[1:0] != 2'b00) : capMis;
    effIdx   = capture ? addr[ADDR_W+1:2] : capIdx;
    effBe    = capture ? be : capBe;
    effWdata = capture ? wdata : capWdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      capWe    <= 1'b0;
      capMis   <= 1'b0;
      capIdx   <= '0;
      capBe    <= '0;
      capWdata <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (capture) begin
        capWe    <= we;
        capMis   <= (addr[1:0] != 2'b00);
        capIdx   <= addr[ADDR_W+1:2];
        capBe    <= be;
        capWdata <= wdata;
      end
      if (enterResp) begin
        err   <= effMis;
        rdata <= (effMis || effWe) ? '0 : mem[effIdx];
      end
    end
  end

  // Storage is never reset; the reset term only blocks writes while reset is held.
  always_ff @(posedge clk) begin
    if (reset && enterResp && effWe && !effMis) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (effBe[i]) mem[effIdx][8*i +: 8] <= effWdata[8*i +: 8];
      end
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

endmodule
